// File: rtl/data_mem_responder.sv
// data_mem_responder: multi-cycle data memory for the MEM stage.
// Holds a DEPTH x WORD_LEN array and freezes the pipeline with a
// combinational stall while a blocking access is in flight.
// Optional feature: define DMEM_WRITE_BUFFER_EN to add a one-entry posted
// write buffer, so stores complete at once and drain in the background.
module data_mem_responder #(
  parameter int LATENCY  = 3,
  parameter int ADDR_LEN = 8,
  parameter int WORD_LEN = 8,
  parameter int DEPTH    = 256
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                mem_read,
  input  logic                mem_write,
  input  logic [ADDR_LEN-1:0] address,
  input  logic [WORD_LEN-1:0] write_data,
  output logic [WORD_LEN-1:0] read_data,
  output logic                stall,
  output logic                ready,
  output logic                protocol_error
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  localparam int CNT_W = $clog2(LATENCY + 1);
  localparam int IDX_W = $clog2(DEPTH);

  state_t               r_state;
  state_t               w_next_state;
  logic [CNT_W-1:0]     r_cnt;
  logic                 r_is_write;
  logic [IDX_W-1:0]     r_addr;
  logic [WORD_LEN-1:0]  r_wdata;
  logic [WORD_LEN-1:0]  r_read_data;
  logic                 r_perr;
  logic [WORD_LEN-1:0]  r_mem [DEPTH];

  logic                 w_rd_req;
  logic                 w_wr_req;
  logic                 w_both;
  logic                 w_blocking_req;
  logic                 w_hold;
  logic                 w_accept;
  logic                 w_last;
  logic                 w_posted_ready;
  logic                 w_acc_is_write;
  logic [IDX_W-1:0]     w_acc_addr;
  logic [WORD_LEN-1:0]  w_acc_data;
  logic                 w_mem_we;
  logic [IDX_W-1:0]     w_mem_waddr;
  logic [WORD_LEN-1:0]  w_mem_wdata;

  assign w_rd_req = mem_read & ~mem_write;
  assign w_wr_req = mem_write & ~mem_read;
  assign w_both   = mem_read & mem_write;

  // In the accept cycle the latches are not loaded yet, so the access
  // source is the live request; afterwards it is the latched copy.
  assign w_acc_is_write = (r_state == IDLE) ? w_wr_req : r_is_write;
  assign w_acc_addr     = (r_state == IDLE) ? address[IDX_W-1:0] : r_addr;
  assign w_acc_data     = (r_state == IDLE) ? write_data : r_wdata;

`ifdef DMEM_WRITE_BUFFER_EN
  logic                 r_wb_valid;
  logic [IDX_W-1:0]     r_wb_addr;
  logic [WORD_LEN-1:0]  r_wb_data;
  logic [CNT_W-1:0]     r_wb_cnt;
  logic                 w_wb_capture;
  logic                 w_wb_drain;

  // Stores are posted; only loads go through the blocking FSM. Any request
  // waits while the buffer is still draining.
  assign w_blocking_req = w_rd_req;
  assign w_hold         = r_wb_valid;
  assign w_wb_capture   = (r_state == IDLE) && w_wr_req && !r_wb_valid;
  assign w_wb_drain     = r_wb_valid && (r_wb_cnt == CNT_W'(1));
  assign w_posted_ready = w_wb_capture;

  assign w_mem_we    = w_wb_drain | (w_last & w_acc_is_write);
  assign w_mem_waddr = w_wb_drain ? r_wb_addr : w_acc_addr;
  assign w_mem_wdata = w_wb_drain ? r_wb_data : w_acc_data;

  // Posted write buffer: capture a store, count down LATENCY cycles, retire.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wb_valid <= 1'b0;
      r_wb_addr  <= '0;
      r_wb_data  <= '0;
      r_wb_cnt   <= '0;
    end else if (w_wb_capture) begin
      r_wb_valid <= 1'b1;
      r_wb_addr  <= address[IDX_W-1:0];
      r_wb_data  <= write_data;
      r_wb_cnt   <= CNT_W'(LATENCY);
    end else if (r_wb_valid) begin
      if (r_wb_cnt == CNT_W'(1)) r_wb_valid <= 1'b0;
      else                       r_wb_cnt   <= r_wb_cnt - CNT_W'(1);
    end
  end
`else
  assign w_blocking_req = w_rd_req | w_wr_req;
  assign w_hold         = 1'b0;
  assign w_posted_ready = 1'b0;

  assign w_mem_we    = w_last & w_acc_is_write;
  assign w_mem_waddr = w_acc_addr;
  assign w_mem_wdata = w_acc_data;
`endif

  assign w_accept = (r_state == IDLE) && w_blocking_req && !w_hold;

  // The edge that ends the last stall cycle performs the array access.
  assign w_last = ((r_state == ACCESS) && (r_cnt == CNT_W'(1))) ||
                  (w_accept && (LATENCY == 1));

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    if (rst) r_state <= IDLE;
    else     r_state <= w_next_state;
  end

  // Next-state logic.
  always_comb begin
    // NOTE: default first so no path leaves the output unassigned (no latch).
    w_next_state = r_state;
    unique case (r_state)
      IDLE:    if (w_accept) w_next_state = (LATENCY == 1) ? DONE : ACCESS;
      ACCESS:  if (r_cnt == CNT_W'(1)) w_next_state = DONE;
      DONE:    w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // Output logic: stall freezes the pipeline, ready marks completion.
  always_comb begin
    stall = 1'b0;
    ready = 1'b0;
    unique case (r_state)
      IDLE: begin
        stall = w_accept | (w_hold & (w_rd_req | w_wr_req));
        ready = w_posted_ready;
      end
      ACCESS:  stall = 1'b1;
      DONE:    ready = 1'b1;
      default: ;
    endcase
  end

  // Request latches, latency counter, load result and sticky error flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt       <= '0;
      r_is_write  <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_read_data <= '0;
      r_perr      <= 1'b0;
    end else begin
      if (w_accept) begin
        r_cnt      <= CNT_W'(LATENCY - 1);
        r_is_write <= w_wr_req;
        r_addr     <= address[IDX_W-1:0];
        r_wdata    <= write_data;
      end else if (r_state == ACCESS) begin
        r_cnt <= r_cnt - CNT_W'(1);
      end
      if (w_last && !w_acc_is_write) r_read_data <= r_mem[w_acc_addr];
      if ((r_state == IDLE) && w_both) r_perr <= 1'b1;
    end
  end

  // Storage array; reset clears every word, discarding any in-flight store.
  always_ff @(posedge clk) begin
    // NOTE: clearing the array on reset is required behaviour here, so the
    // storage is built from resettable flops rather than a RAM macro.
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (w_mem_we) begin
      r_mem[w_mem_waddr] <= w_mem_wdata;
    end
  end

  assign read_data      = r_read_data;
  assign protocol_error = r_perr;

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench for data_mem_responder (LATENCY=3 and LATENCY=1
// instances). Expectations follow the build configuration via
// DMEM_WRITE_BUFFER_EN.
module tb_data_mem_responder;

  localparam int LAT = 3;

  typedef struct {
    bit          is_load;
    logic [7:0]  data;
    int          stall_cycles;
    string       tag;
  } sb_item_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       mem_read, mem_write;
  logic [7:0] address, write_data, read_data;
  logic       stall, ready, protocol_error;

  logic       l1_read, l1_write;
  logic [7:0] l1_address, l1_wdata, l1_rdata;
  logic       l1_stall, l1_ready, l1_perr;

  int         n_cmp = 0;
  int         n_err = 0;
  sb_item_t   sb [$];
  logic [7:0] model [256];
  bit         prev_store = 1'b0;

  always #5 clk = ~clk;

  data_mem_responder #(.LATENCY(LAT), .ADDR_LEN(8), .WORD_LEN(8), .DEPTH(256)) u_dut (
    .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
    .address(address), .write_data(write_data), .read_data(read_data),
    .stall(stall), .ready(ready), .protocol_error(protocol_error)
  );

  data_mem_responder #(.LATENCY(1), .ADDR_LEN(8), .WORD_LEN(8), .DEPTH(256)) u_dut_l1 (
    .clk(clk), .rst(rst), .mem_read(l1_read), .mem_write(l1_write),
    .address(l1_address), .write_data(l1_wdata), .read_data(l1_rdata),
    .stall(l1_stall), .ready(l1_ready), .protocol_error(l1_perr)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Monitor: count stall cycles since the last completion, pop on ready.
  initial begin
    int       stall_cnt;
    sb_item_t it;
    stall_cnt = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        stall_cnt = 0;
      end else begin
        if (stall) stall_cnt++;
        if (ready) begin
          if (sb.size() == 0) begin
            check("unexpected_ready", 32'd1, 32'd0);
          end else begin
            it = sb.pop_front();
            check({it.tag, "_stall"}, stall_cnt, it.stall_cycles);
            if (it.is_load) check({it.tag, "_data"}, {24'd0, read_data}, {24'd0, it.data});
          end
          stall_cnt = 0;
        end
      end
    end
  end

  // Drive one request (caller is just after a rising edge), hold it until
  // ready, then release it after the next rising edge.
  task automatic access(input bit is_load, input logic [7:0] a, input logic [7:0] d,
                        input string tag);
    sb_item_t it;
    int       exp_stall;
    int       n;
`ifdef DMEM_WRITE_BUFFER_EN
    exp_stall = (prev_store ? LAT : 0) + (is_load ? LAT : 0);
`else
    exp_stall = LAT;
`endif
    if (!is_load) model[a] = d;
    it.is_load      = is_load;
    it.data         = model[a];
    it.stall_cycles = exp_stall;
    it.tag          = tag;
    sb.push_back(it);
    prev_store = !is_load;
    mem_read   = is_load;
    mem_write  = !is_load;
    address    = a;
    write_data = d;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!ready && n < 40);
    if (!ready) check({tag, "_timeout"}, 32'd0, 32'd1);
    @(posedge clk);
    #1;
    mem_read  = 1'b0;
    mem_write = 1'b0;
  endtask

  task automatic clear_model();
    for (int i = 0; i < 256; i++) model[i] = 8'h00;
    prev_store = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    rst = 1'b1;
    mem_read = 1'b0; mem_write = 1'b0; address = '0; write_data = '0;
    l1_read = 1'b0; l1_write = 1'b0; l1_address = '0; l1_wdata = '0;
    clear_model();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state.
    @(negedge clk);
    check("rst_stall", {31'd0, stall}, 32'd0);
    check("rst_ready", {31'd0, ready}, 32'd0);
    check("rst_rdata", {24'd0, read_data}, 32'd0);
    check("rst_perr", {31'd0, protocol_error}, 32'd0);
    check("rst_l1_rdata", {24'd0, l1_rdata}, 32'd0);
    @(posedge clk);
    #1;

    // Basic load, store, load back, neighbouring address.
    access(1'b1, 8'h10, 8'h00, "ld10");
    access(1'b0, 8'h20, 8'h5A, "st20");
    access(1'b1, 8'h20, 8'h00, "ld20");
    access(1'b1, 8'h21, 8'h00, "ld21");

    // Illegal request: both read and write high in IDLE.
    mem_read = 1'b1; mem_write = 1'b1; address = 8'h20; write_data = 8'hFF;
    @(negedge clk);
    check("perr_stall", {31'd0, stall}, 32'd0);
    check("perr_ready", {31'd0, ready}, 32'd0);
    check("perr_before", {31'd0, protocol_error}, 32'd0);
    @(posedge clk);
    #1 mem_read = 1'b0; mem_write = 1'b0;
    @(negedge clk);
    check("perr_set", {31'd0, protocol_error}, 32'd1);
    @(posedge clk);
    #1;
    access(1'b1, 8'h20, 8'h00, "ld20_after_perr");
    check("perr_sticky", {31'd0, protocol_error}, 32'd1);

    // Store 0x33 to 0x40 with rst during the second ACCESS cycle.
    mem_write = 1'b1; address = 8'h40; write_data = 8'h33;
`ifdef DMEM_WRITE_BUFFER_EN
    begin
      sb_item_t it;
      it.is_load = 1'b0; it.data = 8'h33; it.stall_cycles = 0; it.tag = "st40";
      sb.push_back(it);
    end
`endif
    @(posedge clk);
`ifdef DMEM_WRITE_BUFFER_EN
    #1 mem_write = 1'b0;
`else
    #1;
`endif
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0; mem_write = 1'b0;
    clear_model();
    @(negedge clk);
    check("rstmid_stall", {31'd0, stall}, 32'd0);
    check("rstmid_ready", {31'd0, ready}, 32'd0);
    check("rstmid_perr", {31'd0, protocol_error}, 32'd0);
    check("rstmid_rdata", {24'd0, read_data}, 32'd0);
    @(posedge clk);
    #1;
    access(1'b1, 8'h40, 8'h00, "ld40_after_rst");
    access(1'b1, 8'h20, 8'h00, "ld20_after_rst");

    // Store followed immediately by a load, then back-to-back stores.
    access(1'b0, 8'h05, 8'h11, "st05");
    access(1'b1, 8'h05, 8'h00, "ld05");
    access(1'b0, 8'h06, 8'h01, "st06a");
    access(1'b0, 8'h06, 8'h02, "st06b");
    access(1'b1, 8'h06, 8'h00, "ld06");

    // Top address and a small block of random data.
    access(1'b0, 8'hFF, 8'hA5, "stFF");
    access(1'b1, 8'hFF, 8'h00, "ldFF");
    for (int i = 0; i < 4; i++)
      access(1'b0, 8'(8'h80 + i), 8'($urandom), $sformatf("st8%0d", i));
    for (int i = 3; i >= 0; i--)
      access(1'b1, 8'(8'h80 + i), 8'h00, $sformatf("ld8%0d", i));
    access(1'b1, 8'h05, 8'h00, "ld05_again");

    // LATENCY=1 instance: store to 0xFF, let any drain finish, then load.
    l1_write = 1'b1; l1_address = 8'hFF; l1_wdata = 8'hC3;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!l1_ready && n < 10);
    check("l1_st_ready", {31'd0, l1_ready}, 32'd1);
    @(posedge clk);
    #1 l1_write = 1'b0;
    repeat (3) @(posedge clk);
    #1 l1_read = 1'b1; l1_address = 8'hFF;
    @(negedge clk);
    check("l1_ld_c1_stall", {31'd0, l1_stall}, 32'd1);
    check("l1_ld_c1_ready", {31'd0, l1_ready}, 32'd0);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("l1_ld_c2_stall", {31'd0, l1_stall}, 32'd0);
    check("l1_ld_c2_ready", {31'd0, l1_ready}, 32'd1);
    check("l1_ld_data", {24'd0, l1_rdata}, 32'h0000_00C3);
    @(posedge clk);
    #1 l1_read = 1'b0;
    @(negedge clk);
    check("l1_ready_pulse", {31'd0, l1_ready}, 32'd0);
    check("l1_data_held", {24'd0, l1_rdata}, 32'h0000_00C3);

    repeat (4) @(posedge clk);
    check("sb_empty", sb.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/data_mem_responder.md
# data_mem_responder

Multi-cycle data-memory responder that serves load/store requests from the pipeline's MEM stage. It owns an internal DEPTH×WORD_LEN storage array with a configurable access latency. It drives a stall back to the pipeline so the MEM-stage register and everything upstream hold while an access is in flight. It replaces the single-cycle data memory, and its request-side port meanings match those of the MEM-stage request signals.

## Interface
- LATENCY, 3, cycles per blocking access (≥1)
- ADDR_LEN, 8, address width
- WORD_LEN, 8, data width
- DEPTH, 256, storage words (= 2^ADDR_LEN)

- clk  in  1  clock, all state on rising edge
- rst  in  1  reset; one clock, reset synchronous, active-high
- mem_read  in  1  load request, held by the pipeline while stall=1
- mem_write  in  1  store request, held by the pipeline while stall=1
- address  in  ADDR_LEN  word address, taken modulo DEPTH
- write_data  in  WORD_LEN  store data
- read_data  out  WORD_LEN  load result, registered, held until the next completed load
- stall  out  1  pipeline freeze; combinational from state and request inputs
- ready  out  1  one-cycle pulse: access completed
- protocol_error  out  1  sticky; set on illegal request, cleared only by rst

## Operation
- FSM states: IDLE, ACCESS, DONE.
- IDLE, exactly one of mem_read/mem_write high: accept the request.
  - Latch op, address, and write_data.
  - Load the latency counter.
  - stall=1 in the accept cycle.
  - Go to ACCESS, or straight to DONE when LATENCY=1.
- ACCESS: stall=1 and the counter decrements each cycle.
  - At the edge ending the last stall cycle, a store writes the array, or a load captures array[address] into read_data.
  - Then go to DONE.
- DONE: stall=0 and ready=1.
  - The pipeline advances at the end of this cycle, so the request inputs still show the completed request.
  - DONE does not sample the inputs; it always returns to IDLE.
- IDLE with both mem_read and mem_write high:
  - Set protocol_error.
  - Accept nothing, stall=0, array unchanged.
- IDLE with no request: stall=0 and ready=0.
- rst, in any state including mid-ACCESS:
  - FSM to IDLE; stall, ready, and protocol_error go to 0; read_data goes to 0.
  - Every array location is cleared to 0.
  - An in-flight store is discarded.

## Timing
- Blocking access: stall is high for exactly LATENCY consecutive cycles, starting with the accept cycle.
- ready pulses in cycle LATENCY+1.
- read_data is valid from the DONE cycle onward.
- The minimum spacing between request acceptances is LATENCY+1 cycles, because DONE never accepts.
- Reset values: stall=0, ready=0, read_data=0, protocol_error=0, state=IDLE, array all 0.
- The stall path is combinational from mem_read/mem_write/state; there is no combinational path from address or write_data to any output.

## Configuration
- DMEM_WRITE_BUFFER_EN defined: a one-entry posted write buffer is added (valid, address, data).
  - Store in IDLE with the buffer empty: the buffer captures address and data.
    - stall=0, and ready pulses in the same cycle.
    - The buffer drains to the array over LATENCY cycles in the background, then becomes empty.
  - Store while the buffer is full: stall until the drain completes, then capture as above.
  - Load while the buffer is full, any address: stall until the drain completes, then perform a normal blocking load.
    - Total stall = remaining drain cycles + LATENCY.
  - rst invalidates the buffer, and the pending store is lost.
- DMEM_WRITE_BUFFER_EN undefined: no buffer; stores block exactly like loads.

## Test plan
- After rst, load from 0x10 with LATENCY=3: stall=1 for 3 cycles, ready pulse in cycle 4, read_data=0x00.
- Store 0x5A to 0x20, then load 0x20, macro off: each access stalls 3 cycles and the load returns 0x5A; a load from 0x21 returns 0x00.
- mem_read=mem_write=1 in IDLE: protocol_error=1 the next cycle, stall=0, and a later load from the given address returns its prior value.
- Store 0x33 to 0x40 with rst asserted during the second ACCESS cycle: stall=0 the cycle after rst, and a later load from 0x40 returns 0x00.
- Macro on, store 0x11 to 0x05 then immediately load 0x05: the store shows stall=0 with a same-cycle ready; the load stalls for remaining drain + 3 cycles and returns 0x11. Back-to-back stores 0x01 and 0x02 to 0x06: the second stalls until the drain completes, and a final load of 0x06 returns 0x02.
- LATENCY=1: a load from 0xFF stalls exactly 1 cycle, ready pulses in cycle 2, and read_data equals the stored value.
